// File: rtl/dpram_pkg.sv
// dpram_pkg: shared FSM state and port-select encodings for the arbitrated dual-port RAM
package dpram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: same-address conflict detection with a round-robin winner between ports A and B
module dpram_arbiter
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  a_req,
  input  logic                  b_req,
  input  logic                  a_we,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  a_ready,
  output logic                  b_ready,
  output logic                  collision
);

  port_e ptr;
  logic  conflict;

  // Two reads of one address coexist; any write to a shared address forces a single winner
  always_comb begin
    conflict  = a_req & b_req & (a_addr == b_addr) & (a_we | b_we);
    collision = run & conflict;
    a_ready   = run & ~(conflict & (ptr == PORT_B));
    b_ready   = run & ~(conflict & (ptr == PORT_A));
  end

  // Hand priority to the other port after every conflict it loses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= PORT_A;
    else if (collision) ptr <= (ptr == PORT_A) ? PORT_B : PORT_A;

endmodule

// File: rtl/dual_port_ram_arb.sv
// dual_port_ram_arb: two-port RAM with power-up clear sweep and same-address arbitration; DPRAM_PARITY_EN adds per-word even parity
module dual_port_ram_arb
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_req,
  input  logic                    b_req,
  input  logic                    a_we,
  input  logic                    b_we,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic                    a_ready,
  output logic                    b_ready,
  output logic                    a_rvalid,
  output logic                    b_rvalid,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic [DATA_WIDTH-1:0]   b_rdata,
`ifdef DPRAM_PARITY_EN
  output logic                    a_perr,
  output logic                    b_perr,
`endif
  output logic                    init_done,
  output logic                    collision
);

  localparam int BW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  state_e                  state;
  logic [ADDR_WIDTH:0]     cnt;
  logic                    run, sweep;
  logic                    a_in, b_in, a_wr, b_wr, a_rd, b_rd;
  logic [DATA_WIDTH-1:0]   a_old, b_old, a_word, b_word;
  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
`ifdef DPRAM_PARITY_EN
  logic                    par [RAM_DEPTH];
`endif

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                  input logic [DATA_WIDTH-1:0] wd,
                                                  input logic [BW-1:0] be);
    merge = old;
    for (int i = 0; i < BW; i++) if (be[i]) merge[i*8+:8] = wd[i*8+:8];
  endfunction

  dpram_arbiter #(.ADDR_WIDTH(ADDR_WIDTH)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .a_req     (a_req),
    .b_req     (b_req),
    .a_we      (a_we),
    .b_we      (b_we),
    .a_addr    (a_addr),
    .b_addr    (b_addr),
    .a_ready   (a_ready),
    .b_ready   (b_ready),
    .collision (collision)
  );

  // Out-of-range accesses are accepted but never touch storage and read as zero
  always_comb begin
    run    = state == ST_RUN;
    sweep  = (state == ST_INIT) && (cnt < DEPTH);
    a_in   = {1'b0, a_addr} < DEPTH;
    b_in   = {1'b0, b_addr} < DEPTH;
    a_old  = a_in ? mem[a_addr] : '0;
    b_old  = b_in ? mem[b_addr] : '0;
    a_word = merge(a_old, a_wdata, a_be);
    b_word = merge(b_old, b_wdata, b_be);
    a_wr   = a_req & a_ready & a_we & a_in;
    b_wr   = b_req & b_ready & b_we & b_in;
    a_rd   = a_req & a_ready & ~a_we;
    b_rd   = b_req & b_ready & ~b_we;
  end

  // Sweep one address per cycle, then spend one extra cycle before entering RUN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      if (cnt == DEPTH) begin
        state     <= ST_RUN;
        init_done <= 1'b1;
      end else cnt <= cnt + 1'b1;
    end

  // Storage is unreset; the sweep clears it and conflicts never let both ports write one word
  always_ff @(posedge clk) begin
    if (sweep) mem[cnt[ADDR_WIDTH-1:0]] <= '0;
    if (a_wr) mem[a_addr] <= a_word;
    if (b_wr) mem[b_addr] <= b_word;
  end

`ifdef DPRAM_PARITY_EN
  // Even parity over the merged word, so a partial write keeps parity consistent
  always_ff @(posedge clk) begin
    if (sweep) par[cnt[ADDR_WIDTH-1:0]] <= 1'b0;
    if (a_wr) par[a_addr] <= ^a_word;
    if (b_wr) par[b_addr] <= ^b_word;
  end

  // Parity error flags travel with the read pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_perr <= 1'b0;
      b_perr <= 1'b0;
    end else begin
      a_perr <= a_rd & a_in & (^a_old ^ par[a_addr]);
      b_perr <= b_rd & b_in & (^b_old ^ par[b_addr]);
    end
`endif

  // Read pipeline: one-cycle valid pulse, data held until the next accepted read
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_rd;
      b_rvalid <= b_rd;
      if (a_rd) a_rdata <= a_old;
      if (b_rd) b_rdata <= b_old;
    end

endmodule

// File: tb/tb_dual_port_ram_arb.sv
// tb_dual_port_ram_arb: randomized and directed checks of dual_port_ram_arb against a behavioural model
`timescale 1ns/1ps
module tb_dual_port_ram_arb;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;
  localparam int BW = DW / 8;

  logic          clk = 0, rst_n = 0;
  logic          a_req = 0, b_req = 0, a_we = 0, b_we = 0;
  logic [BW-1:0] a_be = 0, b_be = 0;
  logic [AW-1:0] a_addr = 0, b_addr = 0;
  logic [DW-1:0] a_wdata = 0, b_wdata = 0;
  logic          a_ready, b_ready, a_rvalid, b_rvalid, init_done, collision;
  logic [DW-1:0] a_rdata, b_rdata;
`ifdef DPRAM_PARITY_EN
  logic          a_perr, b_perr;
`endif

  int n_tests = 0, n_fail = 0;

  logic [DW-1:0] mm [DEPTH];
  int            n_conf;
  logic          exp_av, exp_bv;
  logic [DW-1:0] exp_ad, exp_bd;

  dual_port_ram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .b_req     (b_req),
    .a_we      (a_we),
    .b_we      (b_we),
    .a_be      (a_be),
    .b_be      (b_be),
    .a_addr    (a_addr),
    .b_addr    (b_addr),
    .a_wdata   (a_wdata),
    .b_wdata   (b_wdata),
    .a_ready   (a_ready),
    .b_ready   (b_ready),
    .a_rvalid  (a_rvalid),
    .b_rvalid  (b_rvalid),
    .a_rdata   (a_rdata),
    .b_rdata   (b_rdata),
`ifdef DPRAM_PARITY_EN
    .a_perr    (a_perr),
    .b_perr    (b_perr),
`endif
    .init_done (init_done),
    .collision (collision)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    n_conf = 0;
    exp_ad = '0;
    exp_bd = '0;
  endtask

  task automatic model_write(input logic [AW-1:0] ad, input logic [DW-1:0] wd, input logic [BW-1:0] be);
    for (int i = 0; i < BW; i++) if (be[i]) mm[ad][i*8+:8] = wd[i*8+:8];
  endtask

  task automatic wait_init();
    int n;
    @(negedge clk);
    rst_n = 0;
    #1;
    check("rst_init_done", init_done, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_rvalid", b_rvalid, 0);
    check("rst_collision", collision, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    n = 0;
    while (n < DEPTH + 20) begin
      @(posedge clk);
      #1;
      n++;
      if (init_done) break;
    end
    check("init_cycles", n, DEPTH + 1);
  endtask

  task automatic step(input logic ar, input logic aw, input logic [BW-1:0] abe,
                      input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic br, input logic bw, input logic [BW-1:0] bbe,
                      input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    logic conf, ea, eb;
    @(negedge clk);
    a_req = ar; a_we = aw; a_be = abe; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_be = bbe; b_addr = ba; b_wdata = bd;
    #1;
    conf = ar && br && aa == ba && (aw || bw);
    ea = !conf || (n_conf % 2 == 0);
    eb = !conf || (n_conf % 2 == 1);
    check("a_ready", a_ready, ea);
    check("b_ready", b_ready, eb);
    check("collision", collision, conf);
    if (conf) n_conf++;
    exp_av = ar && ea && !aw;
    exp_bv = br && eb && !bw;
    if (exp_av) exp_ad = mm[aa];
    if (exp_bv) exp_bd = mm[ba];
    if (ar && ea && aw) model_write(aa, ad, abe);
    if (br && eb && bw) model_write(ba, bd, bbe);
    @(posedge clk);
    #1;
    check("a_rvalid", a_rvalid, exp_av);
    check("b_rvalid", b_rvalid, exp_bv);
    check("a_rdata", a_rdata, exp_ad);
    check("b_rdata", b_rdata, exp_bd);
    a_req = 0;
    b_req = 0;
  endtask

  initial begin
    wait_init();
    step(1, 0, 1, 8'h10, 0, 0, 0, 0, 0, 0);
    check("rd10", a_rdata, 8'h00);

    step(1, 1, 1, 8'h05, 8'hAB, 1, 1, 1, 8'h06, 8'hCD);
    step(1, 0, 0, 8'h05, 0, 1, 0, 0, 8'h06, 0);
    check("rd05", a_rdata, 8'hAB);
    check("rd06", b_rdata, 8'hCD);

    repeat (3) step(1, 1, 1, 8'h20, 8'h11, 1, 1, 1, 8'h20, 8'h22);
    step(1, 0, 0, 8'h20, 0, 1, 0, 0, 8'h20, 0);
    check("rd20", a_rdata, 8'h11);

    step(1, 1, 1, 8'h07, 8'h55, 0, 0, 0, 0, 0);
    step(1, 1, 0, 8'h07, 8'h3C, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h07, 0);
    check("rd07", b_rdata, 8'h55);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), BW'($urandom), AW'(8'h60 + $urandom_range(0, 5)), DW'($urandom),
           $urandom_range(0, 1), $urandom_range(0, 1), BW'($urandom), AW'(8'h60 + $urandom_range(0, 5)), DW'($urandom));

`ifdef DPRAM_PARITY_EN
    step(1, 1, 1, 8'h09, 8'h5A, 0, 0, 0, 0, 0);
    dut.par[9] = ~dut.par[9];
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 8'h09;
    @(posedge clk);
    #1;
    a_req = 0;
    check("perr_rvalid", a_rvalid, 1);
    check("perr", a_perr, 1);
`endif

    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 8'h05;
    #2;
    rst_n = 0;
    a_req = 0;
    @(posedge clk);
    #1;
    check("flight_rvalid", a_rvalid, 0);
    check("flight_rdata", a_rdata, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (8'h41) @(posedge clk);
    #1;
    check("sweep_ready", a_ready, 0);
    check("sweep_done", init_done, 0);
    wait_init();
    step(1, 0, 0, 8'h05, 0, 1, 0, 0, 8'h06, 0);
    check("clr05", a_rdata, 8'h00);
    check("clr06", b_rdata, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_arb.md
DUAL_PORT_RAM_ARB -- requirements
Module: dual_port_ram_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width; SHALL be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width.
REQ-003 SHALL have parameter RAM_DEPTH, default 1<<ADDR_WIDTH, number of words.
REQ-004 SHALL have ports, with one clock and an asynchronous active-low reset:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- a_req, b_req  in  1  port access request.
- a_we, b_we  in  1  1 = write, 0 = read.
- a_be, b_be  in  DATA_WIDTH/8  write byte enables.
- a_addr, b_addr  in  ADDR_WIDTH  word address.
- a_wdata, b_wdata  in  DATA_WIDTH  write data.
- a_ready, b_ready  out  1  request accepted this cycle.
- a_rvalid, b_rvalid  out  1  read data valid.
- a_rdata, b_rdata  out  DATA_WIDTH  read data.
- init_done  out  1  memory clear complete.
- collision  out  1  one-cycle pulse when arbitration stalls a port.

Function
REQ-005 SHALL be a two-state FSM: INIT (clear sweep) and RUN.
REQ-006 In INIT, SHALL write zero to addresses 0..RAM_DEPTH-1, one per cycle, in ascending order, with a_ready = b_ready = 0.
REQ-007 SHALL enter RUN, with init_done = 1, in the cycle after address RAM_DEPTH-1 is written.
REQ-008 In RUN, a request SHALL be accepted when x_req & x_ready.
REQ-009 A conflict SHALL be both ports requesting the same address with at least one of them writing.
REQ-010 With no conflict, SHALL accept both ports in the same cycle; two reads of the same address are not a conflict.
REQ-011 On a conflict, SHALL accept only the port named by a round-robin pointer, deassert the other port's ready, and pulse collision for that cycle.
REQ-012 SHALL reset the round-robin pointer to port A and toggle it after each conflict.
REQ-013 An accepted write SHALL update, at that clock edge, only the bytes whose be bit is 1.
REQ-014 An accepted read SHALL return the word in x_rdata with x_rvalid = 1 exactly one cycle later.
REQ-015 x_rvalid SHALL be 1 only in the cycle after an accepted read.
REQ-016 x_rdata SHALL hold its last value until the next accepted read.
REQ-017 Out-of-range addresses (addr >= RAM_DEPTH) SHALL be accepted, ignored for writes, and return zero for reads.

Reset
REQ-018 Asserting rst_n = 0 SHALL immediately force the FSM to INIT, sweep counter = 0, pointer = A, and all outputs to 0.
REQ-019 Reset mid-sweep or mid-RUN SHALL restart the sweep from address 0; a read in flight SHALL be discarded (no rvalid).

Configuration
REQ-020 When DPRAM_PARITY_EN is defined, SHALL store one even-parity bit per word, add outputs a_perr and b_perr (1 bit), and assert x_perr together with x_rvalid when the stored parity mismatches.
REQ-021 When DPRAM_PARITY_EN is undefined, SHALL have no parity storage and no perr ports.

Structure
REQ-022 SHALL place the FSM state encoding (INIT, RUN) and the port-select encoding in a shared package dpram_pkg.
REQ-023 SHALL implement conflict detection and the round-robin pointer in sub-module dpram_arbiter; storage, sweep and read pipeline SHALL be in the top level.

Verification
REQ-024 Reset, then idle -> init_done rises exactly RAM_DEPTH+1 cycles after rst_n deasserts; a read of address 0x10 then returns 0x00.
REQ-025 A writes 0xAB to 0x05 and B writes 0xCD to 0x06 in the same cycle -> both ready = 1; reads return 0xAB and 0xCD one cycle later.
REQ-026 Both ports write 0x20 three cycles in a row (A 0x11, B 0x22) -> A wins, then B, then A; collision pulses on each of the three cycles.
REQ-027 A writes 0x3C to 0x07 with be = 0 on a word holding 0x55 -> a read of 0x07 returns 0x55.
REQ-028 Assert rst_n = 0 mid-sweep at address 0x40 -> the pending rvalid is suppressed, init_done = 0, and the sweep restarts at 0.
REQ-029 With DPRAM_PARITY_EN defined, force one stored bit flip at 0x09 -> the next read of 0x09 asserts a_perr together with a_rvalid.
